// File: rtl/n2t_arb_pkg.sv
// Shared constants for the n2t 16-bit two-source arbiter.
package n2t_arb_pkg;
    localparam int N2T_WORD_W = 16;
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;
    localparam int BURST_MIN = 1;
    localparam int BURST_MAX = 15;
    localparam int CNT_W = 4;
endpackage

// File: rtl/n2t_arb_select.sv
// Burst-limited round-robin grant logic; purely combinational.
module n2t_arb_select
    import n2t_arb_pkg::*;
#(
    parameter int BURST = 4
) (
    input  logic             owner,
    input  logic [CNT_W-1:0] burst_cnt,
    input  logic             a_valid,
    input  logic             b_valid,
    input  logic             load_en,
    output logic             sel,
    output logic             grant,
    output logic             a_ready,
    output logic             b_ready
);
    localparam logic [CNT_W-1:0] BURST_L = CNT_W'(BURST);

    logic owner_valid;
    logic other_valid;

    assign owner_valid = (owner == SRC_B) ? b_valid : a_valid;
    assign other_valid = (owner == SRC_B) ? a_valid : b_valid;

    always_comb begin
        sel   = owner;
        grant = 1'b0;
        // The owner keeps the datapath while it has budget, or when nobody else wants it.
        if (owner_valid && ((burst_cnt < BURST_L) || !other_valid)) begin
            sel   = owner;
            grant = 1'b1;
        end else if (other_valid) begin
            sel   = ~owner;
            grant = 1'b1;
        end
    end

    assign a_ready = load_en && grant && (sel == SRC_A);
    assign b_ready = load_en && grant && (sel == SRC_B);
endmodule

// File: rtl/n2t_mux16.sv
// Mux16: 16-bit two-way word select (sel=0 -> a, sel=1 -> b).
module n2t_mux16
    import n2t_arb_pkg::*;
(
    input  logic [N2T_WORD_W-1:0] a,
    input  logic [N2T_WORD_W-1:0] b,
    input  logic                  sel,
    output logic [N2T_WORD_W-1:0] out
);
    assign out = sel ? b : a;
endmodule

// File: rtl/n2t_mux16_arbiter.sv
// Two-source 16-bit arbiter with a registered output stage.
// Optional per-source handshake counters when N2T_ARB_STATS_EN is defined.
module n2t_mux16_arbiter
    import n2t_arb_pkg::*;
#(
    parameter int BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N2T_WORD_W-1:0] a_data,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [N2T_WORD_W-1:0] b_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    output logic [N2T_WORD_W-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_src
`ifdef N2T_ARB_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [15:0]           a_count,
    output logic [15:0]           b_count
`endif
);
    localparam logic [CNT_W-1:0] BURST_L = CNT_W'(BURST);

    logic                  owner;
    logic [CNT_W-1:0]      burst_cnt;
    logic                  load_en;
    logic                  sel;
    logic                  grant;
    logic                  xfer;
    logic [N2T_WORD_W-1:0] mux_word;

    assign load_en = !out_valid || out_ready;
    assign xfer    = load_en && grant;

    n2t_arb_select #(.BURST(BURST)) u_select (
        .owner     (owner),
        .burst_cnt (burst_cnt),
        .a_valid   (a_valid),
        .b_valid   (b_valid),
        .load_en   (load_en),
        .sel       (sel),
        .grant     (grant),
        .a_ready   (a_ready),
        .b_ready   (b_ready)
    );

    n2t_mux16 u_mux16 (
        .a   (a_data),
        .b   (b_data),
        .sel (sel),
        .out (mux_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_src   <= SRC_A;
            owner     <= SRC_A;
            burst_cnt <= '0;
        end else if (xfer) begin
            out_data  <= mux_word;
            out_src   <= sel;
            out_valid <= 1'b1;
            if (sel == owner) begin
                // Saturate so a long uncontested burst never wraps back into budget.
                burst_cnt <= (burst_cnt >= BURST_L) ? BURST_L : burst_cnt + 1'b1;
            end else begin
                owner     <= sel;
                burst_cnt <= CNT_W'(1);
            end
        end else if (out_ready && out_valid) begin
            out_valid <= 1'b0;
        end
    end

`ifdef N2T_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_count <= '0;
            b_count <= '0;
        end else if (stats_clr) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (a_ready && (a_count != 16'hFFFF)) a_count <= a_count + 16'd1;
            if (b_ready && (b_count != 16'hFFFF)) b_count <= b_count + 16'd1;
        end
    end
`endif
endmodule
